// File: rtl/video_in_pkg.sv
// Shared types and constants for the video-in frame writer.
// The DROP state exists only when VIDEO_IN_DROP_EN is defined.
package video_in_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    WRITE,
    GAP,
    IRQ,
    ERROR
`ifdef VIDEO_IN_DROP_EN
    , DROP
`endif
  } state_t;

  localparam logic [3:0] WB_SEL = 4'hF;

  // Four 8-bit pixels are packed into each 32-bit bus word.
  function automatic int unsigned words_per_frame(input int unsigned width,
                                                  input int unsigned height);
    return (width * height) / 4;
  endfunction

endpackage

// File: rtl/video_in_addr_fifo.sv
// Small synchronous queue of frame-buffer base addresses with a
// show-ahead head word, full/empty flags and a flush-and-load path.
module video_in_addr_fifo #(
  parameter int P_NBUF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = (P_NBUF > 1) ? $clog2(P_NBUF) : 1;
  localparam int CW = $clog2(P_NBUF + 1);

  logic [31:0]   mem [P_NBUF];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(P_NBUF - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(P_NBUF));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  // A pop in the same cycle frees the slot, so push+pop keeps occupancy.
  assign do_push = push && (!full || do_pop || flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? next_ptr('0) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[flush ? '0 : wr_ptr] <= din;
  end

endmodule

// File: rtl/video_in_frame_writer.sv
// Writes whole video frames from a pixel FIFO to memory as Wishbone bursts.
// Optional feature VIDEO_IN_DROP_EN discards frames when no buffer is queued.
module video_in_frame_writer
  import video_in_pkg::*;
#(
  parameter int P_WIDTH   = 640,
  parameter int P_HEIGHT  = 480,
  parameter int P_BURST   = 16,
  parameter int P_NBUF    = 2,
  parameter int P_IRQ_LEN = 3
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic [31:0]                cfg_addr,
  input  logic                       cfg_push,
  output logic                       cfg_full,
  input  logic [31:0]                fifo_data,
  input  logic [$clog2(P_BURST)+1:0] fifo_level,
  output logic                       fifo_rd,
  output logic                       interrupt,
  output logic [31:0]                done_addr,
  output logic                       err_irq,
`ifdef VIDEO_IN_DROP_EN
  output logic [15:0]                drop_cnt,
`endif
  output logic                       p_wb_CYC_O,
  output logic                       p_wb_STB_O,
  output logic                       p_wb_WE_O,
  output logic                       p_wb_LOCK_O,
  output logic [3:0]                 p_wb_SEL_O,
  output logic [31:0]                p_wb_ADR_O,
  output logic [31:0]                p_wb_DAT_O,
  input  logic                       p_wb_ACK_I,
  input  logic                       p_wb_ERR_I
);

  localparam int unsigned WPF         = words_per_frame(P_WIDTH, P_HEIGHT);
  localparam logic [31:0] FRAME_BYTES = 32'(WPF * 4);
  localparam int          BW          = $clog2(P_BURST) + 1;
  localparam int          LW          = $clog2(P_BURST) + 2;
  localparam int          IW          = $clog2(P_IRQ_LEN + 1);

  state_t        state;
  logic [31:0]   base;
  logic [31:0]   offset;
  logic [BW-1:0] beat;
  logic [IW-1:0] irq_cnt;
  logic          cyc;
  logic          q_empty;
  logic          q_pop;
  logic          q_flush;
  logic [31:0]   q_head;
  logic          burst_ready;
  logic          frame_done;
  logic          ack_ok;

  video_in_addr_fifo #(
    .P_NBUF (P_NBUF)
  ) u_addr_fifo (
    .clk   (clk),
    .rst   (RST),
    .flush (q_flush),
    .push  (cfg_push),
    .pop   (q_pop),
    .din   (cfg_addr),
    .dout  (q_head),
    .full  (cfg_full),
    .empty (q_empty)
  );

  assign burst_ready = (fifo_level >= LW'(P_BURST));
  assign frame_done  = (offset == FRAME_BYTES);
  assign ack_ok      = cyc && p_wb_ACK_I && !p_wb_ERR_I;
  // The queue head stays the frame base until the frame completes.
  assign q_pop       = (state == GAP) && frame_done;
  assign q_flush     = (state == ERROR) && cfg_push;

  assign p_wb_CYC_O  = cyc;
  assign p_wb_STB_O  = cyc;
  assign p_wb_WE_O   = cyc;
  assign p_wb_LOCK_O = cyc;
  assign p_wb_SEL_O  = WB_SEL;
  assign p_wb_ADR_O  = base + offset;
  assign p_wb_DAT_O  = fifo_data;

`ifdef VIDEO_IN_DROP_EN
  logic [31:0] drop_left;
  logic        drop_rd;

  assign drop_rd = (state == DROP) && (fifo_level != '0);
  assign fifo_rd = ack_ok || drop_rd;
`else
  assign fifo_rd = ack_ok;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      base      <= '0;
      offset    <= '0;
      beat      <= '0;
      irq_cnt   <= '0;
      cyc       <= 1'b0;
      interrupt <= 1'b0;
      err_irq   <= 1'b0;
      done_addr <= '0;
`ifdef VIDEO_IN_DROP_EN
      drop_left <= '0;
      drop_cnt  <= '0;
`endif
    end else begin
      if (cfg_push) err_irq <= 1'b0;
      case (state)
        IDLE: begin
          if (!q_empty) begin
            base   <= q_head;
            offset <= '0;
            state  <= WAIT_DATA;
          end
`ifdef VIDEO_IN_DROP_EN
          else if (burst_ready) begin
            drop_left <= 32'(WPF);
            state     <= DROP;
          end
`endif
        end
        WAIT_DATA: begin
          if (burst_ready) begin
            cyc   <= 1'b1;
            beat  <= '0;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (p_wb_ERR_I) begin
            cyc     <= 1'b0;
            err_irq <= 1'b1;
            state   <= ERROR;
          end else if (p_wb_ACK_I) begin
            offset <= offset + 32'd4;
            beat   <= beat + BW'(1);
            if (beat == BW'(P_BURST - 1)) begin
              cyc   <= 1'b0;
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (frame_done) begin
            done_addr <= base;
            interrupt <= 1'b1;
            irq_cnt   <= IW'(P_IRQ_LEN - 1);
            state     <= IRQ;
          end else begin
            state <= WAIT_DATA;
          end
        end
        IRQ: begin
          if (irq_cnt == '0) begin
            interrupt <= 1'b0;
            state     <= IDLE;
          end else begin
            irq_cnt <= irq_cnt - IW'(1);
          end
        end
        ERROR: begin
          if (cfg_push) state <= IDLE;
        end
`ifdef VIDEO_IN_DROP_EN
        DROP: begin
          if (drop_rd) begin
            drop_left <= drop_left - 32'd1;
            if (drop_left == 32'd1) begin
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
              state <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_in_frame_writer.sv
// Directed-random bench for video_in_frame_writer: bus writes are checked
// against a frame-level model of addresses and the pixel word stream.
module tb_video_in_frame_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_addr;
  logic        cfg_push;
  logic        cfg_full;
  logic [31:0] fifo_data;
  logic [5:0]  fifo_level;
  logic        fifo_rd;
  logic        interrupt;
  logic [31:0] done_addr;
  logic        err_irq;
  logic        cyc, stb, we, lock;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic        ack, err;
`ifdef VIDEO_IN_DROP_EN
  logic [15:0] drop_cnt;
`endif

  video_in_frame_writer #(
    .P_WIDTH(8), .P_HEIGHT(8), .P_BURST(16), .P_NBUF(2), .P_IRQ_LEN(3)
  ) dut (
    .clk(clk), .RST(rst), .cfg_addr(cfg_addr), .cfg_push(cfg_push),
    .cfg_full(cfg_full), .fifo_data(fifo_data), .fifo_level(fifo_level),
    .fifo_rd(fifo_rd), .interrupt(interrupt), .done_addr(done_addr),
    .err_irq(err_irq),
`ifdef VIDEO_IN_DROP_EN
    .drop_cnt(drop_cnt),
`endif
    .p_wb_CYC_O(cyc), .p_wb_STB_O(stb), .p_wb_WE_O(we), .p_wb_LOCK_O(lock),
    .p_wb_SEL_O(sel), .p_wb_ADR_O(adr), .p_wb_DAT_O(dat_o),
    .p_wb_ACK_I(ack), .p_wb_ERR_I(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Pixel FIFO contents seen by the DUT, and the same words as a stream
  // the model consumes when it predicts bus writes.
  logic [31:0] pix[$];
  logic [31:0] stream[$];
  logic [31:0] wr_adr[$], wr_dat[$];
  logic [31:0] exp_adr[$], exp_dat[$];
  logic [31:0] done_q[$];
  int          irq_lens[$];

  int          ack_pct = 100;
  int          ack_off = 0;
  int          err_at = -1;
  int          stall_at = -1;
  int          stall_left = 0;
  logic [31:0] stall_adr = '0;
  int          stall_cycles = 0;
  int          stall_bad = 0;
  int          beats = 0;
  int          rd_cnt = 0;
  int          inv_bad = 0;
  int          irq_run = 0;
  int          cyc_cycles = 0;
  int          in_drop = 0;
  int          err_fired = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_data  = (pix.size() > 0) ? pix[0] : 32'h0;
    fifo_level = (pix.size() > 63) ? 6'd63 : 6'(pix.size());
  endtask

  task automatic supply(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      pix.push_back(w);
      stream.push_back(w);
    end
    drive_fifo();
  endtask

  // One clock: decide bus response, observe settled outputs, advance.
  task automatic step();
    logic ackv, errv, stalling, rd_now;
    ackv = 1'b0; errv = 1'b0; stalling = 1'b0;
    if (cyc === 1'b1) begin
      if (err_at >= 0 && beats == err_at) begin
        errv = 1'b1;
        err_at = -1;
      end else if (stall_left > 0 && beats == stall_at) begin
        stall_left--;
        stalling = 1'b1;
      end else if (ack_off == 0 && $urandom_range(0, 99) < ack_pct) begin
        ackv = 1'b1;
      end
    end
    ack = ackv;
    err = errv;
    #1;
    rd_now = fifo_rd;
    if (stalling) begin
      stall_cycles++;
      if (fifo_rd !== 1'b0 || cyc !== 1'b1 || adr !== stall_adr) stall_bad++;
    end
    if (cyc === 1'b1) cyc_cycles++;
    if (cyc === 1'b1 && stb === 1'b1 && ackv && !errv) begin
      wr_adr.push_back(adr);
      wr_dat.push_back(dat_o);
      beats++;
    end
    if (rd_now === 1'b1) rd_cnt++;
    if (in_drop == 0 && rd_now !== (cyc & stb & ackv & ~errv)) inv_bad++;
    if (lock !== cyc || stb !== cyc || (cyc === 1'b1 && (we !== 1'b1 || sel !== 4'hF))) inv_bad++;
    if (errv) err_fired = 1;
    if (interrupt === 1'b1) begin
      if (irq_run == 0) done_q.push_back(done_addr);
      irq_run++;
    end else if (irq_run > 0) begin
      irq_lens.push_back(irq_run);
      irq_run = 0;
    end
    @(posedge clk);
    if (rd_now === 1'b1 && pix.size() > 0) void'(pix.pop_front());
    @(negedge clk);
    ack = 1'b0;
    err = 1'b0;
    drive_fifo();
  endtask

  task automatic push(input logic [31:0] a);
    cfg_addr = a;
    cfg_push = 1'b1;
    step();
    cfg_push = 1'b0;
  endtask

  task automatic expect_words(input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      exp_adr.push_back(b + 32'(4 * i));
      exp_dat.push_back(stream.size() > 0 ? stream.pop_front() : 32'hx);
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, 32'(wr_adr.size()), 32'(exp_adr.size()));
    for (int i = 0; i < exp_adr.size() && i < wr_adr.size(); i++) begin
      check($sformatf("%s_adr%0d", tag, i), wr_adr[i], exp_adr[i]);
      check($sformatf("%s_dat%0d", tag, i), wr_dat[i], exp_dat[i]);
    end
    wr_adr.delete(); wr_dat.delete(); exp_adr.delete(); exp_dat.delete();
  endtask

  task automatic run_irqs(input string tag, input int n, input int budget);
    int k = 0;
    while (irq_lens.size() < n && k < budget) begin
      step();
      k++;
    end
    check({tag, "_irq_seen"}, 32'(irq_lens.size()), 32'(n));
  endtask

  task automatic check_irq(input string tag, input logic [31:0] exp_addr);
    logic [31:0] a;
    int l;
    a = (done_q.size() > 0) ? done_q.pop_front() : 32'hx;
    l = (irq_lens.size() > 0) ? irq_lens.pop_front() : -1;
    check({tag, "_done_addr"}, a, exp_addr);
    check({tag, "_irq_len"}, 32'(l), 32'd3);
  endtask

  task automatic new_test();
    beats = 0; rd_cnt = 0; cyc_cycles = 0;
    ack_pct = 100; ack_off = 0; err_at = -1; stall_left = 0; err_fired = 0;
  endtask

  initial begin
    int k;
    rst = 1'b1; cfg_addr = '0; cfg_push = 1'b0; ack = 1'b0; err = 1'b0;
    drive_fifo();
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_lock", 32'(lock), 32'd0);
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_interrupt", 32'(interrupt), 32'd0);
    check("rst_err_irq", 32'(err_irq), 32'd0);
    check("rst_done_addr", done_addr, 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_cfg_full", 32'(cfg_full), 32'd0);
    rst = 1'b0;
    step();

`ifdef VIDEO_IN_DROP_EN
    new_test();
    in_drop = 1;
    supply(16);
    for (int i = 0; i < 40; i++) step();
    check("drop_fifo_left", 32'(pix.size()), 32'd0);
    check("drop_cnt", 32'(drop_cnt), 32'd1);
    check("drop_bus_cycles", 32'(cyc_cycles), 32'd0);
    check("drop_rd_cnt", 32'(rd_cnt), 32'd16);
    stream.delete();
    in_drop = 0;
`endif

    // Single frame, single burst, bus always ready.
    new_test();
    push(32'h1000_0000);
    supply(16);
    run_irqs("single", 1, 200);
    expect_words(32'h1000_0000, 16);
    compare_writes("single");
    check_irq("single", 32'h1000_0000);

    // Two queued buffers, two frames, random bus wait states.
    new_test();
    ack_pct = 70;
    push(32'h0000_0100);
    push(32'h0000_0200);
    check("queue_full", 32'(cfg_full), 32'd1);
    supply(32);
    run_irqs("b2b", 2, 600);
    expect_words(32'h0000_0100, 16);
    expect_words(32'h0000_0200, 16);
    compare_writes("b2b");
    check_irq("b2b_first", 32'h0000_0100);
    check_irq("b2b_second", 32'h0000_0200);
    check("queue_drained", 32'(cfg_full), 32'd0);

    // Five-cycle ACK stall after the fourth word.
    new_test();
    stall_at = 4; stall_left = 5; stall_cycles = 0; stall_bad = 0;
    stall_adr = 32'h0000_2000 + 32'd16;
    push(32'h0000_2000);
    supply(16);
    run_irqs("stall", 1, 200);
    check("stall_cycles", 32'(stall_cycles), 32'd5);
    check("stall_held", 32'(stall_bad), 32'd0);
    expect_words(32'h0000_2000, 16);
    compare_writes("stall");
    check_irq("stall", 32'h0000_2000);

    // Bus error on the fourth word, then restart at a new base.
    new_test();
    err_at = 3;
    push(32'h0000_3000);
    supply(16);
    k = 0;
    while (err_fired == 0 && k < 100) begin
      step();
      k++;
    end
    check("err_seen", 32'(err_fired), 32'd1);
    check("err_cyc_drop", 32'(cyc), 32'd0);
    check("err_irq_set", 32'(err_irq), 32'd1);
    for (int i = 0; i < 5; i++) step();
    check("err_cyc_held_low", 32'(cyc), 32'd0);
    check("err_rd_pulses", 32'(rd_cnt), 32'd3);
    check("err_irq_sticky", 32'(err_irq), 32'd1);
    expect_words(32'h0000_3000, 3);
    compare_writes("err_partial");
    push(32'h0000_4000);
    check("err_irq_cleared", 32'(err_irq), 32'd0);
    supply(3);
    run_irqs("restart", 1, 200);
    expect_words(32'h0000_4000, 16);
    compare_writes("restart");
    check_irq("restart", 32'h0000_4000);

    // Reset in the middle of a burst abandons the frame.
    new_test();
    push(32'h0000_5000);
    supply(16);
    k = 0;
    while (beats < 5 && k < 100) begin
      step();
      k++;
    end
    check("rstmid_beats", 32'(beats), 32'd5);
    expect_words(32'h0000_5000, 5);
    compare_writes("rstmid_partial");
    ack_off = 1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ack_off = 0;
    check("rstmid_cyc", 32'(cyc), 32'd0);
    check("rstmid_stb", 32'(stb), 32'd0);
    check("rstmid_lock", 32'(lock), 32'd0);
    check("rstmid_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rstmid_interrupt", 32'(interrupt), 32'd0);
    check("rstmid_done_addr", done_addr, 32'd0);
    check("rstmid_adr", adr, 32'd0);
    pix.delete();
    stream.delete();
    drive_fifo();
    for (int i = 0; i < 10; i++) step();
    check("rstmid_no_irq", 32'(irq_lens.size() + done_q.size()), 32'd0);
    check("rstmid_idle_bus", 32'(cyc), 32'd0);
    push(32'h0000_6000);
    supply(16);
    run_irqs("after_rst", 1, 200);
    expect_words(32'h0000_6000, 16);
    compare_writes("after_rst");
    check_irq("after_rst", 32'h0000_6000);

    // Address wraps modulo 2^32 with random wait states.
    new_test();
    ack_pct = 80;
    push(32'hFFFF_FFF0);
    supply(16);
    run_irqs("wrap", 1, 400);
    expect_words(32'hFFFF_FFF0, 16);
    compare_writes("wrap");
    check_irq("wrap", 32'hFFFF_FFF0);

    check("bus_invariants", 32'(inv_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
